msx_mouse_joy_port: RTL and testbench
=====================================

// Module: msx_mouse_joy_port
// PURPOSE
//  Per-port MSX general-purpose I/O adapter: converts host joystick bits or host mouse packets
//  into the 6 active-low pin levels an MSX core reads on a joystick port.
//  In mouse mode it implements the MSX mouse nibble protocol, clocked by pin-8 strobe toggles.
//  Adds signed delta accumulation with saturation, per-axis inversion and a programmable timeout.
//  One instance per MSX joystick port, between user_io and emsx_top.
// PARAMETERS
//  DELTA_W    9       width of signed host mouse delta inputs (two's complement)
//  TIMEOUT    100000  clk_sys cycles without a strobe edge before the nibble sequence restarts
//  INVERT_X   1       1: negate X delta before accumulation (MSX X positive = left)
//  INVERT_Y   0       1: negate Y delta before accumulation
// PORTS
//  clk_sys       in   1        system clock (all logic on rising edge)
//  reset         in   1        synchronous, active-high reset
//  mouse_x       in   DELTA_W  signed X movement since last packet
//  mouse_y       in   DELTA_W  signed Y movement since last packet
//  mouse_btn     in   2        mouse buttons, active-high: [0]=left, [1]=right
//  mouse_strobe  in   1        1-cycle pulse: mouse_x/y/btn valid
//  joy_n         in   6        host joystick, active-low: [0]up [1]down [2]left [3]right [4]trigA [5]trigB
//  strobe        in   1        MSX pin-8 output, synchronous to clk_sys
//  port_n        out  6        pin levels to MSX, active-low, same bit order as joy_n
//  mouse_active  out  1        1 = mouse mode selected
//  nib_state     out  2        current protocol state (debug)
// BEHAVIOUR
//  Reset: port_n=6'h3F, mouse_active=0, nib_state=0, accumulators=0, snapshots=0, timeout cnt=0, strobe_d=strobe.
//  Reset has priority over every other event, including mid-sequence.
//  Mode:
//  - mouse_active is set on mouse_strobe.
//  - It is cleared when joy_n != 6'h3F and mouse_strobe is low; mouse_strobe wins if both occur.
//  - On clearing: nib_state=0, accumulators=0.
//  Accumulate:
//  - On mouse_strobe, acc_x <= sat8(acc_x + dx), where dx = INVERT_X ? -mouse_x : mouse_x; Y likewise.
//  - Arithmetic is done at DELTA_W+2 bits; sat8 clamps to [-128,+127].
//  - Accumulation also runs in joystick mode.
//  Edge detection:
//  - strobe_d <= strobe every cycle; edge = strobe ^ strobe_d, in either direction.
//  - Edges are ignored while mouse_active=0.
//  Nibble FSM:
//  - Advances only on an edge; registered; port_n[3:0] updates the cycle after the edge cycle.
//  - S0 -> S1: snap_x<=acc_x, snap_y<=acc_y, clear acc; drive acc_x[7:4].
//    If mouse_strobe occurs in the same cycle, acc <= sat8(0+d): no delta is lost.
//  - S1 -> S2: drive snap_x[3:0].
//  - S2 -> S3: drive snap_y[7:4].
//  - S3 -> S0: drive snap_y[3:0].
//  - The S0 nibble is taken from acc before clearing; it equals snap_x[7:4].
//  Timeout:
//  - Every edge loads cnt=TIMEOUT; cnt decrements while nonzero.
//  - At cnt==1 -> nib_state=0; port_n[3:0] holds its last value.
//  - An edge in the same cycle as cnt==1 takes priority: the FSM advances and cnt is reloaded.
//  Outputs:
//  - mouse_active=1: port_n[5:4] <= ~mouse_btn[1:0], registered on mouse_strobe.
//  - mouse_active=0: port_n <= joy_n, registered, 1-cycle latency.
//  - On entry to mouse mode, port_n[3:0] holds until the first edge.
// TESTING
//  1. Reset, joy_n=6'h3E -> port_n=6'h3E after 1 clk; mouse_active=0; strobe toggles leave nib_state=0.
//  2. mouse_strobe with x=+5 (INVERT_X=1), y=-3; then 4 strobe toggles
//     -> port_n[3:0] = F, B, F, D; nib_state 1,2,3,0; acc=0.
//  3. Three packets x=+100 (dx=-100 each) -> acc_x saturates to -128; next sequence emits nibbles 8,0.
//  4. Two toggles, then TIMEOUT+2 idle cycles -> nib_state=0; next toggle re-snapshots and emits X high nibble.
//  5. mouse_strobe (x=+1) in the same cycle as the S0 edge
//     -> snapshot holds old acc; acc_x=-1 afterwards; next sequence emits F,F.
//  6. Mouse mode in S2, then joy_n=6'h2F
//     -> mouse_active=0, nib_state=0, port_n=6'h2F; reset asserted mid-sequence -> all reset values.

Source files
------------

// File: rtl/msx_mouse_joy_port.sv
// MSX joystick-port adapter: passes host joystick bits through, or emulates an MSX mouse
// by serving accumulated deltas as four nibbles clocked by pin-8 strobe toggles.
module msx_mouse_joy_port #(
    parameter int DELTA_W  = 9,
    parameter int TIMEOUT  = 100000,
    parameter bit INVERT_X = 1'b1,
    parameter bit INVERT_Y = 1'b0
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic signed [DELTA_W-1:0] mouse_x,
    input  logic signed [DELTA_W-1:0] mouse_y,
    input  logic        [1:0]         mouse_btn,
    input  logic                      mouse_strobe,
    input  logic        [5:0]         joy_n,
    input  logic                      strobe,
    output logic        [5:0]         port_n,
    output logic                      mouse_active,
    output logic        [1:0]         nib_state
);

    localparam int SW = DELTA_W + 2;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic signed [SW-1:0] MAX8 = SW'(127);
    localparam logic signed [SW-1:0] MIN8 = -SW'(128);

    typedef enum logic [1:0] {S0, S1, S2, S3} nib_t;

    nib_t            state;
    logic            strobe_d;
    logic [7:0]      acc_x, acc_y, snap_x, snap_y;
    logic [CW-1:0]   cnt;

    logic signed [SW-1:0] dx, dy, sum_x, sum_y;
    logic [7:0]      next_x, next_y, fresh_x, fresh_y;
    logic            edge_ok, leave;

    function automatic logic [7:0] sat8(input logic signed [SW-1:0] v);
        if (v > MAX8)
            return 8'h7F;
        else if (v < MIN8)
            return 8'h80;
        else
            return v[7:0];
    endfunction

    // Deltas are widened by two bits so that negation and the add cannot overflow before clamping.
    always_comb begin
        dx = {{2{mouse_x[DELTA_W-1]}}, mouse_x};
        dy = {{2{mouse_y[DELTA_W-1]}}, mouse_y};
        if (INVERT_X)
            dx = -dx;
        if (INVERT_Y)
            dy = -dy;
        sum_x   = {{(SW-8){acc_x[7]}}, acc_x} + dx;
        sum_y   = {{(SW-8){acc_y[7]}}, acc_y} + dy;
        next_x  = sat8(sum_x);
        next_y  = sat8(sum_y);
        fresh_x = sat8(dx);
        fresh_y = sat8(dy);
        edge_ok = mouse_active && (strobe ^ strobe_d);
        leave   = mouse_active && !mouse_strobe && (joy_n != 6'h3F);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= S0;
            strobe_d     <= strobe;
            acc_x        <= '0;
            acc_y        <= '0;
            snap_x       <= '0;
            snap_y       <= '0;
            cnt          <= '0;
            port_n       <= 6'h3F;
            mouse_active <= 1'b0;
        end else begin
            strobe_d <= strobe;

            if (mouse_strobe)
                mouse_active <= 1'b1;
            else if (joy_n != 6'h3F)
                mouse_active <= 1'b0;

            if (edge_ok)
                cnt <= CW'(TIMEOUT);
            else if (cnt != '0)
                cnt <= cnt - CW'(1);

            if (mouse_strobe) begin
                acc_x       <= next_x;
                acc_y       <= next_y;
                port_n[5:4] <= ~mouse_btn;
            end else if (!mouse_active) begin
                port_n <= joy_n;
            end

            // Later assignments below override the plain accumulate when a sequence starts.
            if (leave) begin
                state <= S0;
                acc_x <= '0;
                acc_y <= '0;
            end else if (edge_ok) begin
                case (state)
                    S0: begin
                        snap_x      <= acc_x;
                        snap_y      <= acc_y;
                        acc_x       <= mouse_strobe ? fresh_x : 8'h00;
                        acc_y       <= mouse_strobe ? fresh_y : 8'h00;
                        port_n[3:0] <= acc_x[7:4];
                        state       <= S1;
                    end
                    S1: begin
                        port_n[3:0] <= snap_x[3:0];
                        state       <= S2;
                    end
                    S2: begin
                        port_n[3:0] <= snap_y[7:4];
                        state       <= S3;
                    end
                    default: begin
                        port_n[3:0] <= snap_y[3:0];
                        state       <= S0;
                    end
                endcase
            end else if (cnt == CW'(1)) begin
                state <= S0;
            end
        end
    end

    assign nib_state = state;

endmodule

// File: tb/tb_msx_mouse_joy_port.sv
// Directed scoreboard bench for msx_mouse_joy_port with a shortened timeout.
module tb_msx_mouse_joy_port;

    localparam int TB_TIMEOUT = 40;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic signed [8:0] mouse_x;
    logic signed [8:0] mouse_y;
    logic [1:0]        mouse_btn;
    logic              mouse_strobe;
    logic [5:0]        joy_n;
    logic              strobe;
    logic [5:0]        port_n;
    logic              mouse_active;
    logic [1:0]        nib_state;

    typedef struct {
        int         id;
        logic [5:0] port;
        logic [1:0] nib;
        logic       active;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   next_id = 0;

    msx_mouse_joy_port #(
        .DELTA_W (9),
        .TIMEOUT (TB_TIMEOUT),
        .INVERT_X(1'b1),
        .INVERT_Y(1'b0)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .mouse_x     (mouse_x),
        .mouse_y     (mouse_y),
        .mouse_btn   (mouse_btn),
        .mouse_strobe(mouse_strobe),
        .joy_n       (joy_n),
        .strobe      (strobe),
        .port_n      (port_n),
        .mouse_active(mouse_active),
        .nib_state   (nib_state)
    );

    always #5 clk_sys = ~clk_sys;

    // Monitor: compares DUT outputs against the oldest pending expectation on each falling edge.
    always @(negedge clk_sys) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (port_n !== e.port || nib_state !== e.nib || mouse_active !== e.active) begin
                errors++;
                $display("[TB] FAIL check%0d: got port_n=%h nib_state=%0d mouse_active=%0b, expected port_n=%h nib_state=%0d mouse_active=%0b",
                         e.id, port_n, nib_state, mouse_active, e.port, e.nib, e.active);
            end
        end
    end

    // One clock of stimulus: optional mouse packet and/or strobe toggle.
    task automatic applyStimulus(input logic pkt, input logic tog,
                                 input logic signed [8:0] x, input logic signed [8:0] y,
                                 input logic [1:0] btn);
        mouse_x      = x;
        mouse_y      = y;
        mouse_btn    = btn;
        mouse_strobe = pkt;
        if (tog)
            strobe = ~strobe;
        @(posedge clk_sys);
        #1;
        mouse_strobe = 1'b0;
    endtask

    task automatic toggle();
        applyStimulus(1'b0, 1'b1, 9'sd0, 9'sd0, 2'b00);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic checkOutput(input logic [5:0] p, input logic [1:0] nb, input logic act);
        exp_t e;
        e.id     = next_id;
        e.port   = p;
        e.nib    = nb;
        e.active = act;
        next_id++;
        exp_q.push_back(e);
        @(negedge clk_sys);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        mouse_x      = '0;
        mouse_y      = '0;
        mouse_btn    = '0;
        mouse_strobe = 1'b0;
        joy_n        = 6'h3F;
        strobe       = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        reset = 1'b0;
        checkOutput(6'h3F, 2'd0, 1'b0);

        // Joystick pass-through; strobe toggles ignored
        joy_n = 6'h3E;
        idle(1);
        checkOutput(6'h3E, 2'd0, 1'b0);
        toggle();
        checkOutput(6'h3E, 2'd0, 1'b0);
        toggle();
        checkOutput(6'h3E, 2'd0, 1'b0);
        joy_n = 6'h3F;
        idle(1);
        checkOutput(6'h3F, 2'd0, 1'b0);

        // x=+5 (inverted -> FB), y=-3 (FD), left button held
        applyStimulus(1'b1, 1'b0, 9'sd5, -9'sd3, 2'b01);
        checkOutput(6'h2F, 2'd0, 1'b1);
        toggle(); checkOutput(6'h2F, 2'd1, 1'b1);
        toggle(); checkOutput(6'h2B, 2'd2, 1'b1);
        toggle(); checkOutput(6'h2F, 2'd3, 1'b1);
        toggle(); checkOutput(6'h2D, 2'd0, 1'b1);

        // Saturation: three x=+100 packets -> -128 (0x80)
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b0, 9'sd100, 9'sd0, 2'b00);
        checkOutput(6'h3D, 2'd0, 1'b1);
        toggle(); checkOutput(6'h38, 2'd1, 1'b1);
        toggle(); checkOutput(6'h30, 2'd2, 1'b1);
        toggle(); checkOutput(6'h30, 2'd3, 1'b1);
        toggle(); checkOutput(6'h30, 2'd0, 1'b1);

        // Timeout: x=+16 -> F0, two toggles, then idle past the timeout
        applyStimulus(1'b1, 1'b0, 9'sd16, 9'sd0, 2'b00);
        toggle(); checkOutput(6'h3F, 2'd1, 1'b1);
        toggle(); checkOutput(6'h30, 2'd2, 1'b1);
        idle(10);
        checkOutput(6'h30, 2'd2, 1'b1);
        idle(TB_TIMEOUT - 8);
        checkOutput(6'h30, 2'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, -9'sd32, 9'sd0, 2'b00);
        toggle(); checkOutput(6'h32, 2'd1, 1'b1);
        toggle(); checkOutput(6'h30, 2'd2, 1'b1);
        toggle(); checkOutput(6'h30, 2'd3, 1'b1);
        toggle(); checkOutput(6'h30, 2'd0, 1'b1);

        // Packet coincident with the S0 edge: snapshot 0x30, acc_x becomes FF
        applyStimulus(1'b1, 1'b0, -9'sd48, 9'sd0, 2'b00);
        applyStimulus(1'b1, 1'b1, 9'sd1, 9'sd0, 2'b00);
        checkOutput(6'h33, 2'd1, 1'b1);
        toggle(); checkOutput(6'h30, 2'd2, 1'b1);
        toggle(); checkOutput(6'h30, 2'd3, 1'b1);
        toggle(); checkOutput(6'h30, 2'd0, 1'b1);
        toggle(); checkOutput(6'h3F, 2'd1, 1'b1);
        toggle(); checkOutput(6'h3F, 2'd2, 1'b1);
        toggle(); checkOutput(6'h30, 2'd3, 1'b1);
        toggle(); checkOutput(6'h30, 2'd0, 1'b1);

        // Leave mouse mode from S2 via joystick activity
        toggle(); checkOutput(6'h30, 2'd1, 1'b1);
        toggle(); checkOutput(6'h30, 2'd2, 1'b1);
        joy_n = 6'h2F;
        idle(1);
        checkOutput(6'h30, 2'd0, 1'b0);
        idle(1);
        checkOutput(6'h2F, 2'd0, 1'b0);
        joy_n = 6'h3F;
        idle(1);
        checkOutput(6'h3F, 2'd0, 1'b0);

        // Reset mid-sequence
        applyStimulus(1'b1, 1'b0, 9'sd0, 9'sd0, 2'b11);
        checkOutput(6'h0F, 2'd0, 1'b1);
        toggle(); checkOutput(6'h00, 2'd1, 1'b1);
        reset = 1'b1;
        idle(1);
        checkOutput(6'h3F, 2'd0, 1'b0);
        reset = 1'b0;
        idle(1);
        checkOutput(6'h3F, 2'd0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk_sys);
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
